// File: rtl/interfere_pcs_hss.sv
// interfere_pcs_hss: registers each TX PCS word and, when enabled, flips LFSR-chosen bits every ERR_PERIOD words.
module interfere_pcs_hss #(
  parameter int          DATA_WIDTH = 32,
  parameter bit          ERR_EN     = 1'b0,
  parameter int          ERR_PERIOD = 4096,
  parameter int          ERR_BITS   = 1,
  parameter logic [31:0] LFSR_SEED  = 32'hACE12468
) (
  input  logic                  TXDCLK,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] Din,
  output logic [DATA_WIDTH-1:0] Dout
);
  localparam int IW = $clog2(DATA_WIDTH);
  localparam int CW = $clog2(ERR_PERIOD) + 1;
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [31:0]           lfsr_q, lfsr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d, mask;
  logic [IW-1:0]         idx, idx2;
  logic                  ev;
  always_comb begin
    ev     = cnt_q == CW'(ERR_PERIOD - 1);
    cnt_d  = ev ? '0 : cnt_q + CW'(1);
    lfsr_d = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
    idx    = lfsr_q[IW-1:0];
    // second bit sits half a word away, so the two flips never coincide
    idx2   = idx + IW'(DATA_WIDTH / 2);
    mask   = (ERR_EN && ev) ? ((ONE << idx) | ((ERR_BITS == 2) ? (ONE << idx2) : '0)) : '0;
    dout_d = Din ^ mask;
  end
  always_ff @(posedge TXDCLK) begin
    if (Rst) begin
      cnt_q  <= '0;
      lfsr_q <= LFSR_SEED;
      dout_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      lfsr_q <= lfsr_d;
      dout_q <= dout_d;
    end
  end
  assign Dout = dout_q;
endmodule

// File: tb/tb_interfere_pcs_hss.sv
// tb_interfere_pcs_hss: five differently configured instances checked against a cycle-count reference model.
module tb_interfere_pcs_hss;
  localparam logic [31:0] SEED = 32'hACE12468;
  logic        clk = 1'b0;
  logic        rst [5];
  logic [31:0] din;
  logic [31:0] dout [5];
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;

  interfere_pcs_hss #(.ERR_EN(1'b0), .ERR_PERIOD(4))                   u0 (.TXDCLK(clk), .Rst(rst[0]), .Din(din), .Dout(dout[0]));
  interfere_pcs_hss #(.ERR_EN(1'b1), .ERR_PERIOD(4),    .ERR_BITS(1)) u1 (.TXDCLK(clk), .Rst(rst[1]), .Din(din), .Dout(dout[1]));
  interfere_pcs_hss #(.ERR_EN(1'b1), .ERR_PERIOD(1),    .ERR_BITS(2)) u2 (.TXDCLK(clk), .Rst(rst[2]), .Din(din), .Dout(dout[2]));
  interfere_pcs_hss #(.ERR_EN(1'b1), .ERR_PERIOD(8),    .ERR_BITS(1)) u3 (.TXDCLK(clk), .Rst(rst[3]), .Din(din), .Dout(dout[3]));
  interfere_pcs_hss #(.ERR_EN(1'b1), .ERR_PERIOD(4096), .ERR_BITS(1)) u4 (.TXDCLK(clk), .Rst(rst[4]), .Din(din), .Dout(dout[4]));

  function automatic logic [31:0] nxt(input logic [31:0] s);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
  endfunction

  // k = words since reset release, s = LFSR value seeded then stepped k times
  function automatic logic [31:0] exp_mask(input int k, input int p, input int b, input logic [31:0] s);
    int i;
    logic [31:0] m;
    if (k % p != p - 1) return 32'h0;
    i = int'(s % 32);
    m = 32'h1 << i;
    if (b == 2) m = m | (32'h1 << ((i + 16) % 32));
    return m;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] v [5];
    v = '{32'h12345678, 32'hDEADBEEF, 32'h0, 32'hFFFFFFFF, 32'hA5A5A5A5};
    rst[0] = 1'b1;
    din = 32'hFFFFFFFF;
    repeat (2) begin
      tick;
      total++;
      if (dout[0] !== 32'h0) begin bad++; $display("FAIL reset_dout got=%h exp=00000000", dout[0]); end
    end
    rst[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      din = v[i];
      tick;
      total++;
      if (dout[0] !== v[i]) begin bad++; $display("FAIL passthru[%0d] got=%h exp=%h", i, dout[0], v[i]); end
    end
  endtask

  task automatic test_period4;
    logic [31:0] m, e;
    rst[1] = 1'b1;
    din = 32'h0;
    tick;
    rst[1] = 1'b0;
    m = SEED;
    for (int k = 0; k < 24; k++) begin
      din = 32'h0;
      tick;
      e = exp_mask(k, 4, 1, m);
      total++;
      if (dout[1] !== e) begin bad++; $display("FAIL p4_word[%0d] got=%h exp=%h", k, dout[1], e); end
      if (k % 4 == 3) begin
        total++;
        if ($countones(dout[1]) != 1) begin bad++; $display("FAIL p4_onehot[%0d] got=%0d exp=1", k, $countones(dout[1])); end
      end
      m = nxt(m);
    end
  endtask

  task automatic test_two_bits;
    logic [31:0] m, x, e;
    int lo, hi;
    rst[2] = 1'b1;
    tick;
    rst[2] = 1'b0;
    m = SEED;
    for (int k = 0; k < 40; k++) begin
      din = $urandom;
      tick;
      x = dout[2] ^ din;
      e = exp_mask(k, 1, 2, m);
      lo = -1;
      hi = -1;
      for (int b = 0; b < 32; b++) if (x[b]) begin if (lo < 0) lo = b; else hi = b; end
      total++;
      if ($countones(x) != 2) begin bad++; $display("FAIL two_pop[%0d] got=%0d exp=2", k, $countones(x)); end
      total++;
      if (hi - lo != 16) begin bad++; $display("FAIL two_gap[%0d] got=%0d exp=16", k, hi - lo); end
      total++;
      if (x !== e) begin bad++; $display("FAIL two_mask[%0d] got=%h exp=%h", k, x, e); end
      m = nxt(m);
    end
  endtask

  task automatic test_mid_reset;
    logic [31:0] pat [30];
    logic [31:0] m, x;
    int first;
    rst[3] = 1'b1;
    tick;
    rst[3] = 1'b0;
    m = SEED;
    first = -1;
    for (int k = 0; k < 30; k++) begin
      din = $urandom;
      tick;
      pat[k] = dout[3] ^ din;
      if (first < 0 && pat[k] != 0) first = k;
      total++;
      if (pat[k] !== exp_mask(k, 8, 1, m)) begin bad++; $display("FAIL fresh[%0d] got=%h exp=%h", k, pat[k], exp_mask(k, 8, 1, m)); end
      m = nxt(m);
    end
    total++;
    if (first != 7) begin bad++; $display("FAIL first_err got=%0d exp=7", first); end
    rst[3] = 1'b1;
    tick;
    rst[3] = 1'b0;
    for (int k = 0; k < 13; k++) begin din = $urandom; tick; end
    rst[3] = 1'b1;
    din = 32'hFFFFFFFF;
    tick;
    total++;
    if (dout[3] !== 32'h0) begin bad++; $display("FAIL midrst_dout got=%h exp=00000000", dout[3]); end
    rst[3] = 1'b0;
    for (int k = 0; k < 30; k++) begin
      din = $urandom;
      tick;
      x = dout[3] ^ din;
      total++;
      if (x !== pat[k]) begin bad++; $display("FAIL replay[%0d] got=%h exp=%h", k, x, pat[k]); end
    end
  endtask

  task automatic test_long;
    logic [31:0] m, x, e;
    int n;
    rst[4] = 1'b1;
    tick;
    rst[4] = 1'b0;
    m = SEED;
    n = 0;
    for (int k = 0; k < 3 * 4096 + 10; k++) begin
      din = k;
      tick;
      x = dout[4] ^ din;
      e = exp_mask(k, 4096, 1, m);
      if (x != 0) n++;
      total++;
      if (x !== e) begin bad++; $display("FAIL long[%0d] got=%h exp=%h", k, x, e); end
      m = nxt(m);
    end
    total++;
    if (n != 3) begin bad++; $display("FAIL long_count got=%0d exp=3", n); end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) rst[i] = 1'b1;
    din = 32'h0;
    tick;
    test_reset;
    test_period4;
    test_two_bits;
    test_mid_reset;
    test_long;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
